// File: rtl/handshake_sync_rx.sv
// Receive side of a toggle req/ack multi-bit CDC: synchronise the request toggle,
// let the foreign data bus settle, capture it into a valid/ready register, then toggle ack.
module handshake_sync_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_req_tgl,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_ack_tgl,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [15:0]           o_xfer_cnt
);

  if (SYNC_STAGES < 2 || SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_param
    $error("handshake_sync_rx: SYNC_STAGES must be >= 2 and SETTLE_CYC in 1..255");
  end

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] req_sync;
  logic       req_s;
  logic       req_seen;
  logic       req_edge;
  logic       slot_free;
  logic       capture;
  logic       violation;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] settle_cnt;
  logic [7:0] settle_cnt_nxt;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], i_req_tgl};
    end
  end

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign req_edge  = req_s ^ req_seen;
  assign slot_free = !o_valid || i_ready;
  assign o_busy    = (state != S_IDLE);

  // A request that flips back before capture means the sender toggled twice without an ack.
  assign violation = (state != S_IDLE) && !req_edge;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    capture        = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_edge) begin
          state_nxt      = S_SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 8'd0) begin
          if (slot_free) begin
            capture   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else begin
          settle_cnt_nxt = settle_cnt - 8'd1;
        end
      end
      S_WAIT: begin
        if (slot_free) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // req_seen follows req_s on capture (normally ~req_seen); after a double toggle this
  // re-aligns detection so the stray toggle never becomes a second transfer.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      req_seen   <= 1'b0;
      o_ack_tgl  <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_xfer_cnt <= '0;
    end else begin
      if (capture) begin
        o_data     <= i_data;
        o_valid    <= 1'b1;
        req_seen   <= req_s;
        o_ack_tgl  <= ~o_ack_tgl;
        o_xfer_cnt <= o_xfer_cnt + 16'd1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (violation) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_sync_rx.sv
// Directed bench for handshake_sync_rx: a default build (SETTLE_CYC=1) and a SETTLE_CYC=4
// build share clock and inputs; inputs change and outputs are sampled on falling edges.
module tb_handshake_sync_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] data;
  logic        ready;

  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, ack_a, ack_b, busy_a, busy_b, err_a, err_b;
  logic [15:0] cnt_a, cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshake_sync_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2), .SETTLE_CYC(1)) dut (
    .i_sys_clk(clk), .i_rst(rst), .i_req_tgl(req), .i_data(data), .i_ready(ready),
    .o_data(data_a), .o_valid(valid_a), .o_ack_tgl(ack_a), .o_busy(busy_a),
    .o_err(err_a), .o_xfer_cnt(cnt_a)
  );

  handshake_sync_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2), .SETTLE_CYC(4)) dut4 (
    .i_sys_clk(clk), .i_rst(rst), .i_req_tgl(req), .i_data(data), .i_ready(ready),
    .o_data(data_b), .o_valid(valid_b), .o_ack_tgl(ack_b), .o_busy(busy_b),
    .o_err(err_b), .o_xfer_cnt(cnt_b)
  );

  task automatic reset_all();
    rst = 1'b1; req = 1'b0; data = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid_a); end
    checks++; if (data_a !== 32'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0h exp=0", ack_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err_a); end
    checks++; if (cnt_a !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt_a); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%0h exp=0", busy_b); end
  endtask

  task automatic test_basic();
    reset_all();
    data = 32'hA5A5_0001; ready = 1'b1; req = 1'b1;
    @(negedge clk); // edge 0
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_e0_busy got=%0h exp=0", busy_a); end
    @(negedge clk); // edge 1
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_e1_busy got=%0h exp=0", busy_a); end
    @(negedge clk); // edge 2: SETTLE
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL basic_e2_busy got=%0h exp=1", busy_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL basic_e2_valid got=%0h exp=0", valid_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL basic_e2_ack got=%0h exp=0", ack_a); end
    @(negedge clk); // edge 3: capture
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL basic_e3_valid got=%0h exp=1", valid_a); end
    checks++; if (data_a !== 32'hA5A5_0001) begin failures++; $display("FAIL basic_e3_data got=%0h exp=a5a50001", data_a); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL basic_e3_ack got=%0h exp=1", ack_a); end
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("FAIL basic_e3_cnt got=%0h exp=1", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_e3_busy got=%0h exp=0", busy_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL basic_e3_err got=%0h exp=0", err_a); end
    @(negedge clk); // edge 4: consumed
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL basic_e4_valid got=%0h exp=0", valid_a); end
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("FAIL basic_e4_cnt got=%0h exp=1", cnt_a); end
  endtask

  task automatic test_back_to_back();
    reset_all();
    ready = 1'b0; data = 32'h11; req = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%0h exp=1", valid_a); end
    checks++; if (data_a !== 32'h11) begin failures++; $display("FAIL b2b_first_data got=%0h exp=11", data_a); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL b2b_first_ack got=%0h exp=1", ack_a); end
    req = 1'b0; data = 32'h22;
    repeat (5) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_wait_busy got=%0h exp=1", busy_a); end
    checks++; if (data_a !== 32'h11) begin failures++; $display("FAIL b2b_wait_data got=%0h exp=11", data_a); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL b2b_wait_ack got=%0h exp=1", ack_a); end
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("FAIL b2b_wait_cnt got=%0h exp=1", cnt_a); end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL b2b_swap_valid got=%0h exp=1", valid_a); end
    checks++; if (data_a !== 32'h22) begin failures++; $display("FAIL b2b_swap_data got=%0h exp=22", data_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL b2b_swap_ack got=%0h exp=0", ack_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_swap_busy got=%0h exp=0", busy_a); end
    checks++; if (cnt_a !== 16'd2) begin failures++; $display("FAIL b2b_swap_cnt got=%0h exp=2", cnt_a); end
    ready = 1'b0;
    @(negedge clk);
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL b2b_hold_valid got=%0h exp=1", valid_a); end
    checks++; if (data_a !== 32'h22) begin failures++; $display("FAIL b2b_hold_data got=%0h exp=22", data_a); end
    ready = 1'b1;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL b2b_drain_valid got=%0h exp=0", valid_a); end
  endtask

  task automatic test_settle4();
    reset_all();
    ready = 1'b1; data = 32'hDEAD_0000; req = 1'b1;
    repeat (3) @(negedge clk); // edge 2: SETTLE entry
    checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL s4_entry_busy got=%0h exp=1", busy_b); end
    data = 32'h1111_1111;
    repeat (3) @(negedge clk); // edge 5: still settling
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL s4_e5_valid got=%0h exp=0", valid_b); end
    checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL s4_e5_busy got=%0h exp=1", busy_b); end
    data = 32'h2222_2222;
    @(negedge clk); // edge 6: capture
    checks++; if (valid_b !== 1'b1) begin failures++; $display("FAIL s4_cap_valid got=%0h exp=1", valid_b); end
    checks++; if (data_b !== 32'h2222_2222) begin failures++; $display("FAIL s4_cap_data got=%0h exp=22222222", data_b); end
    checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL s4_cap_ack got=%0h exp=1", ack_b); end
    checks++; if (cnt_b !== 16'd1) begin failures++; $display("FAIL s4_cap_cnt got=%0h exp=1", cnt_b); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL s4_cap_busy got=%0h exp=0", busy_b); end
  endtask

  task automatic test_reset_mid();
    reset_all();
    ready = 1'b1; data = 32'h33; req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rmid_settle_busy got=%0h exp=1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0h exp=0", valid_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL rmid_ack got=%0h exp=0", ack_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0h exp=0", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0h exp=0", busy_a); end
    repeat (4) @(negedge clk);
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL rmid_recap_valid got=%0h exp=1", valid_a); end
    checks++; if (data_a !== 32'h33) begin failures++; $display("FAIL rmid_recap_data got=%0h exp=33", data_a); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL rmid_recap_ack got=%0h exp=1", ack_a); end
    repeat (8) @(negedge clk);
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("FAIL rmid_once_cnt got=%0h exp=1", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_once_busy got=%0h exp=0", busy_a); end
  endtask

  task automatic test_violation();
    reset_all();
    ready = 1'b1; data = 32'h44; req = 1'b1;
    repeat (3) @(negedge clk); // edge 2: SETTLE entry
    checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL viol_settle_busy got=%0h exp=1", busy_b); end
    req = 1'b0;
    repeat (2) @(negedge clk); // edge 4
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL viol_early_err got=%0h exp=0", err_b); end
    @(negedge clk); // edge 5
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL viol_flag_err got=%0h exp=1", err_b); end
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL viol_e5_valid got=%0h exp=0", valid_b); end
    @(negedge clk); // edge 6: capture still completes
    checks++; if (valid_b !== 1'b1) begin failures++; $display("FAIL viol_cap_valid got=%0h exp=1", valid_b); end
    checks++; if (data_b !== 32'h44) begin failures++; $display("FAIL viol_cap_data got=%0h exp=44", data_b); end
    checks++; if (cnt_b !== 16'd1) begin failures++; $display("FAIL viol_cap_cnt got=%0h exp=1", cnt_b); end
    repeat (10) @(negedge clk);
    checks++; if (cnt_b !== 16'd1) begin failures++; $display("FAIL viol_once_cnt got=%0h exp=1", cnt_b); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL viol_once_busy got=%0h exp=0", busy_b); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL viol_sticky_err got=%0h exp=1", err_b); end
  endtask

  task automatic test_wrap();
    reset_all();
    ready = 1'b1; data = 32'h5555_AAAA;
    for (int i = 0; i < 65535; i++) begin
      req = ~req;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++; if (cnt_a !== 16'hFFFF) begin failures++; $display("FAIL wrap_full_cnt got=%0h exp=ffff", cnt_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL wrap_err got=%0h exp=0", err_a); end
    data = 32'h0BAD_F00D;
    req = ~req;
    repeat (6) @(negedge clk);
    checks++; if (cnt_a !== 16'h0000) begin failures++; $display("FAIL wrap_zero_cnt got=%0h exp=0", cnt_a); end
    checks++; if (data_a !== 32'h0BAD_F00D) begin failures++; $display("FAIL wrap_last_data got=%0h exp=badf00d", data_a); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; data = '0; ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_settle4();
    test_reset_mid();
    test_violation();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
